// File: rtl/serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serializer : parallel-to-serial shifter with pause/resume and done pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_write,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_enable,
  output logic                  out_bit,
  output logic                  out_valid,
  output logic                  out_done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_ZERO = '0;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_count;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_head;
  logic                  w_busy;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = r_shift << 1;
      assign w_head    = r_shift[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = r_shift >> 1;
      assign w_head    = r_shift[0];
    end
  endgenerate

  assign w_busy = (r_count != C_ZERO);

  // Load wins over shift; a load on the final-shift edge therefore drops the done pulse.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_shift <= '0;
      r_count <= C_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (in_write) begin
        r_shift <= in_data;
        r_count <= C_FULL;
      end else if (in_enable && w_busy) begin
        r_shift <= w_shifted;
        r_count <= r_count - C_ONE;
        r_done  <= (r_count == C_ONE);
      end
    end
  end

  assign out_bit   = w_busy & w_head;
  assign out_valid = w_busy;
  assign out_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serializer : scoreboard bench for MSB-first and LSB-first serializers
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serializer;

  typedef struct {
    bit    sel;
    bit    b;
    bit    v;
    bit    d;
    string nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_write, m_enable, l_write, l_enable;
  logic [7:0] m_data, l_data;
  logic       m_bit, m_valid, m_done, l_bit, l_valid, l_done;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .in_clock(clk), .in_reset(rst), .in_write(m_write), .in_data(m_data),
    .in_enable(m_enable), .out_bit(m_bit), .out_valid(m_valid), .out_done(m_done)
  );

  serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .in_clock(clk), .in_reset(rst), .in_write(l_write), .in_data(l_data),
    .in_enable(l_enable), .out_bit(l_bit), .out_valid(l_valid), .out_done(l_done)
  );

  // Monitor: every falling edge, compare the oldest expectation against the selected DUT
  initial begin
    exp_t e;
    logic ab, av, ad;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        ab = e.sel ? l_bit   : m_bit;
        av = e.sel ? l_valid : m_valid;
        ad = e.sel ? l_done  : m_done;
        n_vec++;
        if (ab !== e.b || av !== e.v || ad !== e.d) begin
          n_bad++;
          $display("FAIL %s: bit/valid/done got %b%b%b expected %b%b%b",
                   e.nm, ab, av, ad, e.b, e.v, e.d);
        end
      end
    end
  end

  task automatic push(input bit sel, input bit b, input bit v, input bit d, input string nm);
    exp_t e;
    e.sel = sel; e.b = b; e.v = v; e.d = d; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input bit sel, input bit r, input bit w, input bit en,
                      input logic [7:0] d, input bit eb, input bit ev,
                      input bit ed, input string nm);
    @(negedge clk);
    rst = r;
    m_write = 1'b0; m_enable = 1'b0; l_write = 1'b0; l_enable = 1'b0;
    if (sel) begin l_write = w; l_enable = en; l_data = d; end
    else     begin m_write = w; m_enable = en; m_data = d; end
    @(posedge clk);
    push(sel, eb, ev, ed, nm);
  endtask

  // Shift a freshly loaded MSB-first word out completely, then one idle cycle
  task automatic drain_msb(input logic [7:0] w, input int from, input string nm);
    for (int i = from; i < 8; i++)
      step(0, 0, 0, 1, 8'h00, w[7-i], 1'b1, 1'b0, nm);
    step(0, 0, 0, 1, 8'h00, 1'b0, 1'b0, 1'b1, {nm, "_done"});
    step(0, 0, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, {nm, "_idle"});
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    m_write = 1'b0; m_enable = 1'b0; m_data = 8'h00;
    l_write = 1'b0; l_enable = 1'b0; l_data = 8'h00;

    // Reset state, and inputs ignored while reset is held
    step(0, 1, 0, 0, 8'h00, 0, 0, 0, "reset_state");
    step(0, 1, 1, 1, 8'hFF, 0, 0, 0, "reset_ignores_write");
    step(1, 1, 1, 1, 8'hFF, 0, 0, 0, "reset_ignores_write_lsb");

    // 0xAA: load, 3 shifts, pause, then resume to completion
    w = 8'hAA;
    step(0, 0, 1, 0, w, 1, 1, 0, "aa_load");
    for (int i = 1; i <= 3; i++) step(0, 0, 0, 1, 8'h00, w[7-i], 1, 0, "aa_shift");
    for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 8'h00, 0, 1, 0, "aa_pause");
    drain_msb(w, 4, "aa_resume");

    // Simultaneous write and enable: load only
    w = 8'hB5;
    step(0, 0, 1, 1, w, 1, 1, 0, "b5_load_en");
    drain_msb(w, 1, "b5");

    // Overwrite mid-word with 0x00 restarts a full 8-bit count
    step(0, 0, 1, 0, 8'hFF, 1, 1, 0, "ff_load");
    step(0, 0, 0, 1, 8'h00, 1, 1, 0, "ff_shift");
    step(0, 0, 0, 1, 8'h00, 1, 1, 0, "ff_shift");
    step(0, 0, 1, 0, 8'h00, 0, 1, 0, "overwrite_00");
    drain_msb(8'h00, 1, "zero_word");

    // Load on the final-shift edge suppresses done
    w = 8'hC3;
    step(0, 0, 1, 0, w, 1, 1, 0, "c3_load");
    for (int i = 1; i < 8; i++) step(0, 0, 0, 1, 8'h00, w[7-i], 1, 0, "c3_shift");
    step(0, 0, 1, 1, 8'h5A, 0, 1, 0, "reload_no_done");
    drain_msb(8'h5A, 1, "5a");

    // Enable when empty
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'h00, 0, 0, 0, "empty_enable");

    // Asynchronous reset between edges mid-word
    step(0, 0, 1, 0, 8'hFF, 1, 1, 0, "pre_reset_load");
    step(0, 0, 0, 1, 8'h00, 1, 1, 0, "pre_reset_shift");
    @(negedge clk);
    m_enable = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    push(0, 0, 0, 0, "async_reset_clear");
    step(0, 1, 0, 1, 8'h00, 0, 0, 0, "reset_no_done");
    w = 8'h80;
    step(0, 0, 1, 0, w, 1, 1, 0, "post_reset_load");
    drain_msb(w, 1, "post_reset");

    // LSB-first instance
    w = 8'h01;
    step(1, 0, 1, 0, w, 1, 1, 0, "lsb_load");
    for (int i = 1; i < 8; i++) step(1, 0, 0, 1, 8'h00, w[i], 1, 0, "lsb_shift");
    step(1, 0, 0, 1, 8'h00, 0, 0, 1, "lsb_done");
    w = 8'h96;
    step(1, 0, 1, 0, w, 0, 1, 0, "lsb_load96");
    for (int i = 1; i < 8; i++) step(1, 0, 0, 1, 8'h00, w[i], 1, 0, "lsb96_shift");
    step(1, 0, 0, 1, 8'h00, 0, 0, 1, "lsb96_done");
    step(1, 0, 0, 0, 8'h00, 0, 0, 0, "lsb96_idle");

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = transmit bit DATA_WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 Port in_clock, input, 1, is the single clock; all state SHALL change only on its rising edge, except on reset.
REQ-004 Port in_reset, input, 1, SHALL be an asynchronous, active-high reset.
REQ-005 Port in_write, input, 1, SHALL request loading of in_data.
REQ-006 Port in_data, input, DATA_WIDTH, is the parallel word to serialize.
REQ-007 Port in_enable, input, 1, SHALL request a one-bit shift.
REQ-008 Port out_bit, output, 1, is the current serial bit.
REQ-009 Port out_valid, output, 1, SHALL be high while unsent bits remain.
REQ-010 Port out_done, output, 1, SHALL be a one-cycle pulse after the last bit of a word is shifted out.

Function
REQ-011 The block SHALL hold a DATA_WIDTH shift register and a remaining-bit counter of width clog2(DATA_WIDTH+1).
REQ-012 On a rising edge with in_write=1, the shift register SHALL load in_data and the counter SHALL become DATA_WIDTH.
REQ-013 in_write SHALL take priority over in_enable: when both are high, the edge performs a load only, with no shift.
REQ-014 A write while bits remain SHALL discard the unsent bits and restart with the new word.
REQ-015 On a rising edge with in_write=0, in_enable=1 and counter>0: the register SHALL shift one place toward the output end, fill with 0, and decrement the counter.
REQ-016 in_enable with counter=0 SHALL leave all state unchanged.
REQ-017 out_bit SHALL be driven from a register, not from in_data: register bit DATA_WIDTH-1 when MSB_FIRST=1, bit 0 otherwise.
REQ-018 The first bit SHALL therefore appear on out_bit in the cycle after the loading edge (zero added latency).
REQ-019 Each subsequent bit SHALL appear after each qualifying shift edge.
REQ-020 out_bit SHALL be 0 whenever the counter is 0.
REQ-021 out_valid SHALL equal (counter != 0).
REQ-022 out_done SHALL go high for exactly one cycle following the edge on which the counter goes from 1 to 0 by a shift; a load on that edge SHALL suppress it.
REQ-023 in_enable deasserted SHALL hold out_bit and the counter indefinitely (pause/resume support).

Reset
REQ-024 Asserting in_reset SHALL immediately clear the shift register and counter, regardless of in_clock.
REQ-025 During reset: out_bit=0, out_valid=0, out_done=0.
REQ-026 While in_reset is high, in_write and in_enable SHALL be ignored.
REQ-027 Reset mid-word SHALL abandon the word with no out_done pulse.
REQ-028 After reset is released, the first rising edge SHALL be fully functional.

Verification
REQ-029 Load then partial shift: write 0xAA, then hold enable for 3 edges.
  -> out_bit sequence 1,0,1,0.
  -> out_valid=1 with counter 5.
  -> out_bit held at 0 after enable drops.
REQ-030 Simultaneous write and enable: write=1, enable=1, data 0xB5, then enable held for 8 edges.
  -> out_bit 1 after the load edge, then 0,1,1,0,1,0,1.
  -> out_done pulses once after the 8th shift.
  -> out_bit=0 and out_valid=0 afterwards.
REQ-031 Overwrite mid-word: load 0xFF, shift 2, write 0x00.
  -> out_bit=0, counter=8, out_valid=1, no out_done.
REQ-032 Enable when empty: 10 enable edges with no load.
  -> out_bit=0, out_valid=0, out_done never pulses.
REQ-033 Asynchronous reset: assert in_reset between clock edges mid-word.
  -> outputs clear before the next edge.
  -> a later load of 0x80 yields out_bit 1 then 0.
REQ-034 LSB-first: MSB_FIRST=0, load 0x01, shift.
  -> out_bit 1, then 0 for the remaining 7 bits.
